a2d_sequencer: RTL and testbench
================================

Name: a2d_sequencer

Overview:
Upstream control stage for the SPI master. Converts a channel-conversion request into the two-transaction SPI exchange the external 8-channel A2D needs. Transaction 1 sends the channel command. Transaction 2 clocks the 12-bit result back. The block drives the master's wrt/cmd, consumes its done/rx_data, and presents a registered result plus status to the system, either on demand or in a free-running round-robin scan.

Parameters:
NUM_CH, 8, number of channels scanned in scan mode (1..8); channel indices 0..NUM_CH-1.
RES_W, 12, result width taken from the LSBs of rx_data.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
strt_cnv  in  1  single-conversion request, sampled only in IDLE.
chnl  in  3  channel for strt_cnv, captured with it.
scan_en  in  1  level; enables round-robin auto conversion.
wrt  out  1  one-cycle start pulse to the SPI master.
cmd  out  16  command word to the SPI master, held stable from wrt until done.
done  in  1  SPI master transaction complete (1-cycle pulse, master already idle).
rx_data  in  16  SPI master received word, valid on the done cycle.
res  out  RES_W  last conversion result.
res_ch  out  3  channel of res.
res_vld  out  1  one-cycle pulse when res/res_ch update.
cnv_cmplt  out  1  level: set with res_vld, cleared on next accepted start.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: wrt=0, cmd=16'h0000, res=0, res_ch=0, res_vld=0, cnv_cmplt=0, busy=0, scan_ptr=0, state=IDLE.
- All outputs are registered.
- Channel command word: {2'b00, ch[2:0], 11'h000}. Read word: 16'h0000.
- FSM states:
  - IDLE:
    - strt_cnv=1: latch cur_ch=chnl, pulse wrt next cycle with the channel command, go TX1. strt_cnv wins over scan_en when both are high.
    - else scan_en=1: cur_ch=scan_ptr, same launch.
    - Accepted start clears cnv_cmplt.
  - TX1: wait for done; rx_data is ignored. On done go GAP.
  - GAP: exactly one cycle. Pulse wrt with cmd=16'h0000, go TX2.
  - TX2: wait for done. On done capture res=rx_data[RES_W-1:0] and res_ch=cur_ch the next cycle, pulse res_vld, set cnv_cmplt, go IDLE.
    - If this was a scan conversion: scan_ptr = (scan_ptr==NUM_CH-1) ? 0 : scan_ptr+1.
- Latency: wrt rises 1 clk after the accepted start. res_vld rises 1 clk after the second done.
- Scan throughput: next wrt issued 1 clk after res_vld (IDLE re-launch).
- Requests ignored while busy: strt_cnv/chnl changes have no effect; no queueing.
- scan_en deasserted mid-conversion: current conversion completes and reports; no further launch. scan_ptr holds.
- A demand conversion does not advance scan_ptr.
- done in IDLE or GAP (spurious) is ignored.
- Reset mid-operation: returns immediately to reset values. The SPI master is reset by the same rst_n.

Optional Feature:
A2D_TIMEOUT_EN:
- Defined: 11-bit watchdog cleared on each wrt, counting in TX1/TX2. At count 2047 without done, abort to IDLE and pulse new output port err for 1 cycle. res, res_ch and cnv_cmplt are unchanged; scan_ptr still advances in scan mode. The err port exists only when the macro is defined.
- Undefined: no watchdog, no err port; TX1/TX2 wait indefinitely.

Test Plan:
- Single conversion: strt_cnv with chnl=5; slave model returns 16'hF ABC on transaction 2. Required: first cmd=16'h2800, second cmd=16'h0000, res=12'hABC, res_ch=5, one res_vld, cnv_cmplt=1, exactly two wrt pulses.
- Scan wrap: NUM_CH=3, scan_en held, results 0x100+ch per channel. Required: res_ch sequence 0,1,2,0,1 with matching res; GAP is exactly 1 clk between done and the second wrt.
- Priority/ignore: strt_cnv(chnl=7) and scan_en rise in the same cycle. Required: channel 7 converted first, scan_ptr still 0. A further strt_cnv pulse during TX1 produces no extra conversion.
- Mid-scan disable: drop scan_en during TX1 of ch 2. Required: ch 2 result reported, then busy=0 and no further wrt for 200 clk.
- Reset during TX2: assert rst_n low. Required: all outputs at reset values immediately (asynchronous); a fresh strt_cnv afterwards completes normally.
- A2D_TIMEOUT_EN: slave model never returns done after wrt. Required: err pulses 2048 clk after wrt, res unchanged, busy=0.

Source files
------------

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: turns a channel-conversion request into the two SPI
// transactions the external 8-channel A2D needs. The first transaction sends
// the channel command and the second clocks the 12-bit result back.
// It supports single conversions on demand and a round-robin scan mode.
// Optional feature: define A2D_TIMEOUT_EN to add an 11-bit transaction
// watchdog and the err output port.
module a2d_sequencer #(
  parameter int NUM_CH = 8,
  parameter int RES_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_cnv,
  input  logic [2:0]       chnl,
  input  logic             scan_en,
  output logic             wrt,
  output logic [15:0]      cmd,
  input  logic             done,
  input  logic [15:0]      rx_data,
  output logic [RES_W-1:0] res,
  output logic [2:0]       res_ch,
  output logic             res_vld,
  output logic             cnv_cmplt,
  output logic             busy
`ifdef A2D_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX1  = 2'd1,
    GAP  = 2'd2,
    TX2  = 2'd3
  } state_t;

  localparam logic [2:0] SCAN_LAST = 3'(NUM_CH - 1);

  state_t state, state_nxt;

  logic [2:0]       cur_ch, cur_ch_nxt;
  logic [2:0]       scan_ptr, scan_ptr_nxt;
  logic             is_scan, is_scan_nxt;
  logic             wrt_nxt;
  logic [15:0]      cmd_nxt;
  logic [RES_W-1:0] res_nxt;
  logic [2:0]       res_ch_nxt;
  logic             res_vld_nxt;
  logic             cnv_cmplt_nxt;
  logic             launch;
  logic [2:0]       launch_ch;
  logic             finish;

`ifdef A2D_TIMEOUT_EN
  logic [10:0] wdog, wdog_nxt;
  logic        err_nxt;
`endif

  // Bits of rx_data above the result field carry nothing for this A2D.
  generate
    if (RES_W < 16) begin : g_rx_unused
      logic rx_unused;
      assign rx_unused = ^rx_data[15:RES_W];
    end
  endgenerate

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_nxt     = state;
    cur_ch_nxt    = cur_ch;
    scan_ptr_nxt  = scan_ptr;
    is_scan_nxt   = is_scan;
    wrt_nxt       = 1'b0;
    cmd_nxt       = cmd;
    res_nxt       = res;
    res_ch_nxt    = res_ch;
    res_vld_nxt   = 1'b0;
    cnv_cmplt_nxt = cnv_cmplt;
    launch        = 1'b0;
    launch_ch     = 3'd0;
    finish        = 1'b0;
`ifdef A2D_TIMEOUT_EN
    wdog_nxt      = wdog;
    err_nxt       = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (strt_cnv) begin
          launch      = 1'b1;
          launch_ch   = chnl;
          is_scan_nxt = 1'b0;
        end else if (scan_en) begin
          launch      = 1'b1;
          launch_ch   = scan_ptr;
          is_scan_nxt = 1'b1;
        end
      end

      TX1: begin
        if (done) begin
          state_nxt = GAP;
        end
`ifdef A2D_TIMEOUT_EN
        else if (wdog == 11'h7FF) begin
          finish  = 1'b1;
          err_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + 11'd1;
        end
`endif
      end

      GAP: begin
        wrt_nxt   = 1'b1;
        cmd_nxt   = 16'h0000;
        state_nxt = TX2;
`ifdef A2D_TIMEOUT_EN
        wdog_nxt  = 11'd0;
`endif
      end

      TX2: begin
        if (done) begin
          finish        = 1'b1;
          res_nxt       = rx_data[RES_W-1:0];
          res_ch_nxt    = cur_ch;
          res_vld_nxt   = 1'b1;
          cnv_cmplt_nxt = 1'b1;
        end
`ifdef A2D_TIMEOUT_EN
        else if (wdog == 11'h7FF) begin
          finish  = 1'b1;
          err_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + 11'd1;
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (launch) begin
      cur_ch_nxt    = launch_ch;
      wrt_nxt       = 1'b1;
      cmd_nxt       = {2'b00, launch_ch, 11'h000};
      cnv_cmplt_nxt = 1'b0;
      state_nxt     = TX1;
`ifdef A2D_TIMEOUT_EN
      wdog_nxt      = 11'd0;
`endif
    end

    if (finish) begin
      state_nxt = IDLE;
      if (is_scan) begin
        scan_ptr_nxt = (scan_ptr == SCAN_LAST) ? 3'd0 : scan_ptr + 3'd1;
      end
    end
  end

  // State and output registers; busy reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_ch    <= 3'd0;
      scan_ptr  <= 3'd0;
      is_scan   <= 1'b0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      res       <= '0;
      res_ch    <= 3'd0;
      res_vld   <= 1'b0;
      cnv_cmplt <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_ch    <= cur_ch_nxt;
      scan_ptr  <= scan_ptr_nxt;
      is_scan   <= is_scan_nxt;
      wrt       <= wrt_nxt;
      cmd       <= cmd_nxt;
      res       <= res_nxt;
      res_ch    <= res_ch_nxt;
      res_vld   <= res_vld_nxt;
      cnv_cmplt <= cnv_cmplt_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef A2D_TIMEOUT_EN
  // Watchdog counter and the one-cycle abort indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= 11'd0;
      err  <= 1'b0;
    end else begin
      wdog <= wdog_nxt;
      err  <= err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: directed bench for a2d_sequencer with a small SPI slave
// model and a queue of expected conversion results.
module tb_a2d_sequencer;

  localparam int NUM_CH = 3;
  localparam int RES_W  = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             strt_cnv = 1'b0;
  logic [2:0]       chnl = 3'd0;
  logic             scan_en = 1'b0;
  logic             done = 1'b0;
  logic [15:0]      rx_data = 16'h0000;
  logic             wrt;
  logic [15:0]      cmd;
  logic [RES_W-1:0] res;
  logic [2:0]       res_ch;
  logic             res_vld;
  logic             cnv_cmplt;
  logic             busy;
`ifdef A2D_TIMEOUT_EN
  logic             err;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [14:0] exp_q[$];
  logic [15:0] cmd_log[$];
  int          wrt_count = 0;
  int          vld_count = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  int          last_gap = -1;
  logic        phase = 1'b0;
  logic [2:0]  sch = 3'd0;
  int          cd = 0;
  logic        silent = 1'b0;
  logic        fixed_en = 1'b0;
  logic [15:0] fixed_reply = 16'h0000;

  a2d_sequencer #(.NUM_CH(NUM_CH), .RES_W(RES_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnl      (chnl),
    .scan_en   (scan_en),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rx_data   (rx_data),
    .res       (res),
    .res_ch    (res_ch),
    .res_vld   (res_vld),
    .cnv_cmplt (cnv_cmplt),
    .busy      (busy)
`ifdef A2D_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] reply(input logic [2:0] ch);
    return fixed_en ? fixed_reply : (16'h0100 + {13'd0, ch});
  endfunction

  // SPI master/slave model: answers each wrt with done three cycles later.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done  = 1'b0;
      phase = 1'b0;
      cd    = 0;
    end else begin
      cyc++;
      done = 1'b0;
      if (res_vld) vld_count++;
      if (wrt) begin
        wrt_count++;
        cmd_log.push_back(cmd);
        if (!phase) sch = cmd[13:11];
        else last_gap = cyc - done_cyc;
        phase = ~phase;
        cd = silent ? 0 : 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done     = 1'b1;
          done_cyc = cyc;
          rx_data  = phase ? 16'hDEAD : reply(sch);
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_wrt"}, {31'd0, wrt}, 32'd0);
    check_output({tag, "_cmd"}, {16'd0, cmd}, 32'd0);
    check_output({tag, "_res"}, {20'd0, res}, 32'd0);
    check_output({tag, "_res_ch"}, {29'd0, res_ch}, 32'd0);
    check_output({tag, "_res_vld"}, {31'd0, res_vld}, 32'd0);
    check_output({tag, "_cnv_cmplt"}, {31'd0, cnv_cmplt}, 32'd0);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic apply_stimulus(input logic [2:0] ch, input logic [11:0] exp_res);
    exp_q.push_back({ch, exp_res});
    strt_cnv = 1'b1;
    chnl     = ch;
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  task automatic wait_result(input string tag, input bit relaunch);
    int n;
    logic [14:0] e;
    n = 0;
    while (!res_vld && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_vld"}, {31'd0, res_vld}, 32'd1);
    if (res_vld) begin
      check_output({tag, "_sb_size"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output({tag, "_res"}, {20'd0, res}, {20'd0, e[11:0]});
        check_output({tag, "_res_ch"}, {29'd0, res_ch}, {29'd0, e[14:12]});
      end
      check_output({tag, "_cnv_cmplt"}, {31'd0, cnv_cmplt}, 32'd1);
      check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
      if (relaunch) begin
        @(negedge clk);
        check_output({tag, "_relaunch_wrt"}, {31'd0, wrt}, 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int base_w;
    int base_v;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_busy", {31'd0, busy}, 32'd0);

    // Single conversion on channel 5
    fixed_en    = 1'b1;
    fixed_reply = 16'hFABC;
    cmd_log.delete();
    base_w = wrt_count;
    base_v = vld_count;
    apply_stimulus(3'd5, 12'hABC);
    check_output("single_wrt", {31'd0, wrt}, 32'd1);
    check_output("single_cmd1", {16'd0, cmd}, 32'h2800);
    check_output("single_busy", {31'd0, busy}, 32'd1);
    wait_result("single", 1'b0);
    @(negedge clk);
    check_output("single_vld_pulse", {31'd0, res_vld}, 32'd0);
    check_output("single_cmplt_hold", {31'd0, cnv_cmplt}, 32'd1);
    check_output("single_wrt_count", wrt_count - base_w, 32'd2);
    check_output("single_vld_count", vld_count - base_v, 32'd1);
    check_output("single_log_size", cmd_log.size(), 32'd2);
    if (cmd_log.size() >= 2) begin
      check_output("single_log_cmd1", {16'd0, cmd_log[0]}, 32'h2800);
      check_output("single_log_cmd2", {16'd0, cmd_log[1]}, 32'h0000);
    end
    check_output("single_gap", last_gap, 32'd2);

    // Demand request and scan enable together: demand wins, scan starts at 0
    fixed_en = 1'b0;
    scan_en  = 1'b1;
    exp_q.push_back({3'd7, 12'h107});
    exp_q.push_back({3'd0, 12'h100});
    exp_q.push_back({3'd1, 12'h101});
    exp_q.push_back({3'd2, 12'h102});
    exp_q.push_back({3'd0, 12'h100});
    exp_q.push_back({3'd1, 12'h101});
    strt_cnv = 1'b1;
    chnl     = 3'd7;
    @(negedge clk);
    strt_cnv = 1'b0;
    check_output("prio_cmd", {16'd0, cmd}, 32'h3800);
    @(negedge clk);
    strt_cnv = 1'b1;
    chnl     = 3'd2;
    @(negedge clk);
    strt_cnv = 1'b0;
    wait_result("prio", 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_result("scan", 1'b1);
      check_output("scan_gap", last_gap, 32'd2);
    end

    // Drop scan enable during TX1 of channel 2
    scan_en = 1'b0;
    check_output("disable_cmd", {16'd0, cmd}, 32'h1000);
    exp_q.push_back({3'd2, 12'h102});
    wait_result("disable", 1'b0);
    base_w = wrt_count;
    repeat (200) @(negedge clk);
    check_output("disable_no_wrt", wrt_count - base_w, 32'd0);
    check_output("disable_busy", {31'd0, busy}, 32'd0);
    check_output("disable_sb_empty", exp_q.size(), 32'd0);

    // Asynchronous reset while waiting in TX2
    apply_stimulus(3'd3, 12'h103);
    void'(exp_q.pop_back());
    n = 0;
    while (!(wrt && cmd == 16'h0000) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("rst_tx2_reached", {31'd0, wrt}, 32'd1);
    check_output("rst_tx2_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(3'd6, 12'h106);
    check_output("post_rst_cmd", {16'd0, cmd}, 32'h3000);
    wait_result("post_rst", 1'b0);

`ifdef A2D_TIMEOUT_EN
    // Slave never answers: watchdog aborts 2048 cycles after wrt
    @(negedge clk);
    silent = 1'b1;
    apply_stimulus(3'd4, 12'h000);
    void'(exp_q.pop_back());
    check_output("tmo_wrt", {31'd0, wrt}, 32'd1);
    n = 0;
    while (!err && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check_output("tmo_latency", n, 32'd2048);
    check_output("tmo_err", {31'd0, err}, 32'd1);
    check_output("tmo_busy", {31'd0, busy}, 32'd0);
    check_output("tmo_res", {20'd0, res}, 32'h106);
    check_output("tmo_res_ch", {29'd0, res_ch}, 32'd6);
    check_output("tmo_res_vld", {31'd0, res_vld}, 32'd0);
    @(negedge clk);
    check_output("tmo_err_pulse", {31'd0, err}, 32'd0);
    check_output("tmo_cnv_cmplt", {31'd0, cnv_cmplt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
